seq_stage_ctrl: RTL

Sequencing controller for the sequential Y86 core. Owns the architectural PC and steps one instruction through fetch, decode, execute, memory, writeback and PC-update phases, one phase per clock, raising a one-hot enable per phase. Captures the fetch outputs, the execute condition and the memory read value, computes the next PC, and maintains the Y86 status code (AOK/HLT/ADR/INS). Drives `pc` into the combinational fetch block and enables the downstream datapath blocks.

---
 rtl/seq_stage_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/seq_stage_ctrl.sv
// seq_stage_ctrl -- sequencing controller for the sequential Y86 core.
//
// Owns the architectural PC and moves one instruction at a time through
// FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PCUPD, one phase per clock,
// with a one-hot enable per phase. It captures the fetch outputs, the execute
// condition and the memory read value, selects the next PC, and keeps the Y86
// status code (1=AOK, 2=HLT, 3=ADR, 4=INS).
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   start                    one-cycle pulse that leaves IDLE
//   step                     (SEQ_SINGLE_STEP_EN only) releases WAIT into FETCH
//   icode, ifun, valC, valP,
//   instr_valid, imem_error  fetch results, sampled in FETCH
//   cnd                      execute condition, sampled in EXECUTE
//   valM, dmem_error         memory results, sampled in MEMORY
//   pc                       architectural PC driven into fetch
//   fetch_en .. pcup_en      one-hot phase enables
//   stat                     Y86 status code
//   halted, busy             HALT state / any active phase
//   instr_count              retired-instruction counter (wraps)
//
// Build option: define SEQ_SINGLE_STEP_EN to add the `step` input and a WAIT
// state between PCUPD and the next FETCH.

module seq_stage_ctrl #(
  parameter int unsigned       ADDR_W   = 11,
  parameter logic [ADDR_W-1:0] START_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [63:0]       valC,
  input  logic [ADDR_W-1:0] valP,
  input  logic              instr_valid,
  input  logic              imem_error,
  input  logic              cnd,
  input  logic [63:0]       valM,
  input  logic              dmem_error,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_en,
  output logic              decode_en,
  output logic              exec_en,
  output logic              mem_en,
  output logic              wb_en,
  output logic              pcup_en,
  output logic [2:0]        stat,
  output logic              halted,
  output logic              busy,
  output logic [31:0]       instr_count
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPD,
    S_HALT
`ifdef SEQ_SINGLE_STEP_EN
    , S_WAIT
`endif
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [2:0]        stat_q;
  logic [31:0]       count_q;
  logic [3:0]        icode_q;
  logic [63:0]       valC_q;
  logic [ADDR_W-1:0] valP_q;
  logic              cnd_q;
  logic [63:0]       valM_q;

  logic [63:0]       pc_src_d;
  logic              pc_src_oob;

  // ifun is carried to the datapath by the fetch block itself; nothing here decodes it.
  logic unused_ifun;
  assign unused_ifun = ^ifun;

  // Next-PC source is formed at full 64-bit width so that out-of-range
  // call/jump/return targets can be caught before truncation.
  always_comb begin
    pc_src_d = {{(64-ADDR_W){1'b0}}, valP_q};
    case (icode_q)
      4'h7:    if (cnd_q) pc_src_d = valC_q;
      4'h8:    pc_src_d = valC_q;
      4'h9:    pc_src_d = valM_q;
      default: ;
    endcase
  end

  assign pc_src_oob = |pc_src_d[63:ADDR_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= START_PC;
      stat_q  <= STAT_AOK;
      count_q <= '0;
      icode_q <= '0;
      valC_q  <= '0;
      valP_q  <= '0;
      cnd_q   <= 1'b0;
      valM_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) state_q <= S_FETCH;
        end
        S_FETCH: begin
          icode_q <= icode;
          valC_q  <= valC;
          valP_q  <= valP;
          if (imem_error) begin
            stat_q  <= STAT_ADR;
            state_q <= S_HALT;
          end else if (!instr_valid) begin
            stat_q  <= STAT_INS;
            state_q <= S_HALT;
          end else if (icode == 4'h0) begin
            stat_q  <= STAT_HLT;
            state_q <= S_HALT;
          end else begin
            state_q <= S_DECODE;
          end
        end
        S_DECODE: state_q <= S_EXECUTE;
        S_EXECUTE: begin
          cnd_q   <= cnd;
          state_q <= S_MEMORY;
        end
        S_MEMORY: begin
          valM_q <= valM;
          if (dmem_error) begin
            stat_q  <= STAT_ADR;
            state_q <= S_HALT;
          end else begin
            state_q <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: state_q <= S_PCUPD;
        S_PCUPD: begin
          if (pc_src_oob) begin
            stat_q  <= STAT_ADR;
            state_q <= S_HALT;
          end else begin
            pc_q    <= pc_src_d[ADDR_W-1:0];
            count_q <= count_q + 32'd1;
`ifdef SEQ_SINGLE_STEP_EN
            state_q <= S_WAIT;
`else
            state_q <= S_FETCH;
`endif
          end
        end
`ifdef SEQ_SINGLE_STEP_EN
        S_WAIT: begin
          if (step) state_q <= S_FETCH;
        end
`endif
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pc          = pc_q;
  assign stat        = stat_q;
  assign instr_count = count_q;
  assign fetch_en    = (state_q == S_FETCH);
  assign decode_en   = (state_q == S_DECODE);
  assign exec_en     = (state_q == S_EXECUTE);
  assign mem_en      = (state_q == S_MEMORY);
  assign wb_en       = (state_q == S_WRITEBACK);
  assign pcup_en     = (state_q == S_PCUPD);
  assign halted      = (state_q == S_HALT);
`ifdef SEQ_SINGLE_STEP_EN
  assign busy        = !(state_q inside {S_IDLE, S_HALT, S_WAIT});
`else
  assign busy        = !(state_q inside {S_IDLE, S_HALT});
`endif

endmodule
